// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter and its
// round-robin picker.
package eth_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int MAX_PORTS   = 8;
  localparam int FRAME_CNT_W = 16;

  function automatic int next_port(input int idx, input int num_ports);
    return (idx + 1) % num_ports;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward
// from i_ptr with wrap-around.
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_W-1:0]    i_ptr,
  output logic [PORT_W-1:0]    o_winner,
  output logic                 o_any_req
);

  always_comb begin
    int w_idx;
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_PORTS;
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req = 1'b1;
        o_winner  = PORT_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the TX MAC stream; grant is held to tlast.
// Optional per-port frame counters via ETH_TX_ARB_FRAME_CNT_EN.
module eth_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter  int NUM_PORTS  = 2,
  localparam int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_trdy,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [CTRL_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_trdy,
  output logic [PORT_W-1:0]               o_grant,
  output logic                            o_busy
`ifdef ETH_TX_ARB_FRAME_CNT_EN
  ,
  output logic [NUM_PORTS*FRAME_CNT_W-1:0] o_frame_cnt
`endif
);

  arb_state_t        r_state, w_state_nxt;
  logic [PORT_W-1:0] r_grant, w_grant_nxt;
  logic [PORT_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [PORT_W-1:0] w_winner;
  logic              w_any_req;
  logic              w_busy;
  logic              w_sel_vld;
  logic              w_sel_last;
  logic              w_xfer;
  logic              w_eof;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .i_req     (s_axis_tvalid),
    .i_ptr     (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_busy     = (r_state == ARB_BUSY);
  assign w_sel_vld  = s_axis_tvalid[r_grant];
  assign w_sel_last = s_axis_tlast[r_grant];
  assign w_xfer     = w_busy && w_sel_vld && m_axis_trdy;
  assign w_eof      = w_xfer && w_sel_last;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_trdy   = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt = w_winner;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        m_axis_tvalid        = w_sel_vld;
        s_axis_trdy[r_grant] = m_axis_trdy;
        // Idle beats inside a frame present zeros rather than stale source data.
        if (w_sel_vld) begin
          m_axis_tdata = s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tkeep = s_axis_tkeep[int'(r_grant)*CTRL_WIDTH +: CTRL_WIDTH];
          m_axis_tlast = w_sel_last;
        end
        if (w_eof) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = PORT_W'(next_port(int'(r_grant), NUM_PORTS));
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign o_grant = r_grant;
  assign o_busy  = w_busy;

`ifdef ETH_TX_ARB_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt [NUM_PORTS];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_frame_cnt[p] <= '0;
    end else if (w_eof) begin
      r_frame_cnt[r_grant] <= r_frame_cnt[r_grant] + FRAME_CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign o_frame_cnt[g*FRAME_CNT_W +: FRAME_CNT_W] = r_frame_cnt[g];
  end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter against a frame-queue reference model.
module tb_eth_tx_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int PW = $clog2(NP);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*CW-1:0] s_tkeep;
  logic [NP-1:0]   s_tvalid, s_tlast, s_trdy;
  logic [DW-1:0]   m_tdata;
  logic [CW-1:0]   m_tkeep;
  logic            m_tvalid, m_tlast, m_trdy;
  logic [PW-1:0]   o_grant;
  logic            o_busy;
`ifdef ETH_TX_ARB_FRAME_CNT_EN
  logic [NP*16-1:0] frame_cnt;
`endif

  eth_tx_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_trdy(m_trdy),
    .o_grant(o_grant), .o_busy(o_busy)
`ifdef ETH_TX_ARB_FRAME_CNT_EN
    , .o_frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] k;
    logic          l;
  } beat_t;

  beat_t srcq [NP][$];
  int    order [$];
  int    owner, ptr, last_grant, stall_left, trdy_pct, gap_pct;
  int    sent [NP];
  int    gap_left [NP];
  int    cnt [NP];
  int    gap_trig_port, gap_trig_beat, gap_trig_len;
  bit    stall_arm;
  logic [NP-1:0] drv_vld;
  int    n_err = 0;
  int    n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (srcq[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      srcq[p].delete();
      sent[p] = 0; gap_left[p] = 0; cnt[p] = 0;
    end
    owner = -1; ptr = 0; last_grant = 0; stall_left = 0; stall_arm = 0;
    gap_trig_port = -1;
  endtask

  task automatic add_frame(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = $urandom;
      b.l = (i == len - 1);
      b.k = b.l ? 4'($urandom_range(15, 1)) : 4'hF;
      srcq[p].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    logic  v;
    for (int p = 0; p < NP; p++) begin
      v = (srcq[p].size() > 0);
      if (v && gap_left[p] > 0) begin
        v = 1'b0;
        gap_left[p]--;
      end
      drv_vld[p] = v;
      if (v) b = srcq[p][0];
      else begin
        b.d = $urandom; b.k = 4'($urandom); b.l = 1'($urandom);
      end
      s_tdata[p*DW +: DW] = b.d;
      s_tkeep[p*CW +: CW] = b.k;
      s_tlast[p]          = b.l;
      s_tvalid[p]         = v;
    end
    if (stall_arm && owner >= 0 && sent[owner] == 2) begin
      stall_left = 3;
      stall_arm  = 0;
    end
    if (stall_left > 0) begin
      m_trdy = 1'b0;
      stall_left--;
    end else begin
      m_trdy = ($urandom_range(99) < trdy_pct);
    end
  endtask

  task automatic check();
    beat_t h;
    if (owner < 0) begin
      chk("idle_tvalid", m_tvalid, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_trdy", s_trdy, 0);
      chk("idle_tdata", m_tdata, 0);
      chk("idle_tkeep", m_tkeep, 0);
      chk("idle_tlast", m_tlast, 0);
      chk("idle_grant", o_grant, last_grant);
    end else begin
      chk("busy", o_busy, 1);
      chk("grant", o_grant, owner);
      chk("tvalid", m_tvalid, drv_vld[owner]);
      chk("src_trdy", s_trdy, m_trdy ? (NP'(1) << owner) : NP'(0));
      if (drv_vld[owner]) begin
        h = srcq[owner][0];
        chk("tdata", m_tdata, h.d);
        chk("tkeep", m_tkeep, h.k);
        chk("tlast", m_tlast, h.l);
      end else begin
        chk("gap_tdata", m_tdata, 0);
        chk("gap_tkeep", m_tkeep, 0);
        chk("gap_tlast", m_tlast, 0);
      end
    end
  endtask

  task automatic update();
    beat_t h;
    int    o;
    bit    found;
    if (owner >= 0) begin
      o = owner;
      if (drv_vld[o] && m_trdy) begin
        h = srcq[o].pop_front();
        sent[o]++;
        if (h.l) begin
          cnt[o]++;
          sent[o] = 0;
          ptr     = (o + 1) % NP;
          owner   = -1;
        end else if (gap_trig_port == o && sent[o] == gap_trig_beat) begin
          gap_left[o]   = gap_trig_len;
          gap_trig_port = -1;
        end else if ($urandom_range(99) < gap_pct) begin
          gap_left[o] = $urandom_range(3, 1);
        end
      end
    end else if (rst_n) begin
      found = 0;
      for (int i = 0; i < NP; i++) begin
        o = (ptr + i) % NP;
        if (!found && drv_vld[o]) begin
          found = 1; owner = o; last_grant = o; order.push_back(o);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check();
    update();
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((owner >= 0 || pending()) && c < budget) begin
      cycle();
      c++;
    end
    chk("drain_done", (owner >= 0 || pending()), 0);
    cycle();
    cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, c1;
    rst_n = 1'b0; s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_trdy = 1'b0;
    trdy_pct = 100; gap_pct = 0;
    model_reset();
    #3;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_trdy", s_trdy, 0);
`ifdef ETH_TX_ARB_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: single 4-beat frame from port 0
    begin
      beat_t b;
      for (int i = 0; i < 4; i++) begin
        b.d = $urandom; b.k = (i == 3) ? 4'h3 : 4'hF; b.l = (i == 3);
        srcq[0].push_back(b);
      end
    end
    order.delete();
    cycle();
    chk("t1_first_beat_latency", m_tvalid, 0);
    cycle();
    chk("t1_first_beat_valid", m_tvalid, 1);
    drain(50);
    chk("t1_grant", o_grant, 0);
    chk("t1_frames", cnt[0], 1);

    // Test 2: both ports stream 3-beat frames from rr_ptr=0
    apply_reset();
    order.delete();
    for (int i = 0; i < 2; i++) begin
      add_frame(0, 3);
      add_frame(1, 3);
    end
    drain(100);
    chk("t2_n_frames", order.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", order[i], i % 2);

    // Test 3: granted source drops valid for 5 cycles mid-frame
    order.delete();
    add_frame(0, 8);
    add_frame(1, 2);
    gap_trig_port = 0; gap_trig_beat = 2; gap_trig_len = 5;
    drain(100);
    chk("t3_gap_taken", gap_trig_port, -1);
    chk("t3_order0", order[0], 0);
    chk("t3_order1", order[1], 1);

    // Test 4: MAC back-pressure on beat 2
    add_frame(0, 4);
    stall_arm = 1;
    drain(100);
    chk("t4_stall_taken", stall_arm, 0);

    // Test 5: reset in the middle of a frame
    add_frame(0, 4);
    begin
      int c = 0;
      while (sent[0] < 2 && c < 30) begin
        cycle();
        c++;
      end
      chk("t5_reach_beat2", sent[0], 2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_tvalid", m_tvalid, 0);
    chk("t5_async_tdata", m_tdata, 0);
    chk("t5_async_tkeep", m_tkeep, 0);
    chk("t5_async_tlast", m_tlast, 0);
    chk("t5_async_trdy", s_trdy, 0);
    chk("t5_async_busy", o_busy, 0);
    chk("t5_async_grant", o_grant, 0);
    model_reset();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    add_frame(1, 1);
    drain(50);
    chk("t5_new_grant", o_grant, 1);

    // Test 6: 100 frames alternating between ports 0 and 1
    c0 = cnt[0]; c1 = cnt[1];
    order.delete();
    for (int i = 0; i < 50; i++) begin
      add_frame(0, $urandom_range(4, 1));
      add_frame(1, $urandom_range(4, 1));
    end
    drain(3000);
    chk("t6_port0_frames", cnt[0] - c0, 50);
    chk("t6_port1_frames", cnt[1] - c1, 50);
    chk("t6_first_port", order[0], 0);
`ifdef ETH_TX_ARB_FRAME_CNT_EN
    chk("t6_cnt0", frame_cnt[15:0], 16'(cnt[0]));
    chk("t6_cnt1", frame_cnt[31:16], 16'(cnt[1]));
`endif

    // Random traffic on all ports with back-pressure and mid-frame gaps
    trdy_pct = 70; gap_pct = 20;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 10; i++) add_frame(p, $urandom_range(6, 1));
    drain(5000);
`ifdef ETH_TX_ARB_FRAME_CNT_EN
    for (int p = 0; p < NP; p++) chk("rand_frame_cnt", frame_cnt[p*16 +: 16], 16'(cnt[p]));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
